tlul_host_bridge: RTL
=====================

Name: tlul_host_bridge

Overview:
- Upstream stage for the TL-UL LED slave. Converts a simple single-command request/response interface (CPU or test sequencer side) into TileLink-UL A-channel transactions. Captures the D-channel reply and returns it.
- Allows one outstanding transaction at a time.
- Its A/D ports connect directly to the slave's TL-UL ports. The LED slave's 8-bit o_data reflects writes issued here.

Parameters:
- AW, 8, address width (i_cmd_addr, o_a_address).
- SRC_W, 2, a_source/d_source width; ID counter wraps at 2^SRC_W.
- TIMEOUT_CYCLES, 16, D-channel wait limit. Used only with the optional feature; must be >= 2.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  bridge accepts command
- i_cmd_we  in  1  1 = write (PutFullData), 0 = read (Get)
- i_cmd_addr  in  AW  byte address
- i_cmd_wdata  in  32  write data
- i_cmd_be  in  4  byte enables
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed
- o_rsp_rdata  out  32  read data (0 for writes)
- o_rsp_err  out  1  slave error, source mismatch or timeout
- o_a_valid  out  1  TL-UL A valid
- i_a_ready  in  1  TL-UL A ready
- o_a_opcode  out  3  0 = PutFullData, 4 = Get
- o_a_param  out  3  always 0
- o_a_size  out  2  always 2 (4 bytes)
- o_a_source  out  SRC_W  transaction ID
- o_a_address  out  AW  address
- o_a_mask  out  4  byte mask
- o_a_data  out  32  write data
- i_d_valid  in  1  TL-UL D valid
- o_d_ready  out  1  TL-UL D ready
- i_d_opcode  in  3  0 = AccessAck, 1 = AccessAckData
- i_d_source  in  SRC_W  response ID
- i_d_data  in  32  read data
- i_d_error  in  1  slave error

Behaviour:
- Clock and reset: one clock, i_clk. i_reset_n is asynchronous, active-low. Asserting it clears all state immediately, whatever the FSM state.
- Reset values:
  - FSM = IDLE, source counter = 0.
  - o_cmd_ready = 1.
  - o_a_valid, o_rsp_valid, o_rsp_err = 0.
  - o_rsp_rdata = 0, all o_a_* payloads = 0.
  - o_d_ready = 0.
- FSM states IDLE, REQ, RESP, DONE.
- IDLE:
  - o_cmd_ready = 1 (registered).
  - On i_cmd_valid: latch the command into the A payload.
  - Set o_a_opcode from i_cmd_we.
  - o_a_mask = i_cmd_be for writes, 4'hF for reads.
  - o_a_source = counter.
  - Next state REQ; o_cmd_ready drops the next cycle.
- REQ:
  - o_a_valid = 1; payload held stable until accepted (TL-UL rule).
  - On i_a_ready: clear o_a_valid, increment counter modulo 2^SRC_W, go to RESP.
  - A handshake takes at least one cycle after acceptance; minimum command-to-A latency is 1 cycle.
- RESP:
  - o_d_ready = 1.
  - On i_d_valid:
    - o_rsp_rdata = i_d_data if i_d_opcode = 1, else 0.
    - o_rsp_err = i_d_error OR (i_d_source != o_a_source) OR (opcode does not match the request type: AccessAckData expected for Get, AccessAck for Put).
    - Go to DONE.
  - D is accepted in the same cycle that i_d_valid is seen.
- DONE:
  - o_rsp_valid = 1; rdata and err held stable.
  - On i_rsp_ready: clear o_rsp_valid, go to IDLE with o_cmd_ready = 1 the next cycle.
- Simultaneous events:
  - i_cmd_valid while not IDLE is ignored; o_cmd_ready = 0.
  - i_d_valid outside RESP is not acknowledged: o_d_ready = 0.
- Counter wrap: source 2^SRC_W-1 is followed by 0.

Optional Feature:
- Macro: TLUL_HOST_TIMEOUT_EN
- Defined:
  - A counter clears on entry to RESP and increments each RESP cycle without i_d_valid.
  - At TIMEOUT_CYCLES: go to DONE with o_rsp_err = 1 and o_rsp_rdata = 0.
  - In IDLE, o_d_ready = 1 so stale late responses are drained and discarded.
- Undefined: no counter; RESP waits indefinitely; o_d_ready = 0 in IDLE.

Test Plan:
- Write: cmd we=1, addr=0x00, wdata=0x000000A5, be=4'h1, a_ready held 1, slave AccessAck source 0 -> A beat opcode 0, mask 1, data 0xA5; rsp valid, err=0, rdata=0; LED slave o_data=8'hA5.
- Read: cmd we=0, addr=0x00; slave returns AccessAckData, data 0xA5 -> A opcode 4, mask F; o_rsp_rdata=0x000000A5, err=0.
- Backpressure: a_ready low 5 cycles, then high; rsp_ready low 3 cycles -> A payload stable throughout REQ; rsp stays valid and stable until i_rsp_ready; no second cmd accepted.
- ID/error: 5 back-to-back commands -> a_source 0,1,2,3,0. Reply with mismatched d_source -> err=1. Reply with d_error=1 -> err=1.
- Reset mid-transaction: drop i_reset_n during RESP -> all outputs at reset values asynchronously; after release, o_cmd_ready=1, source restarts at 0.
- With TLUL_HOST_TIMEOUT_EN, no D response -> rsp valid with err=1 exactly TIMEOUT_CYCLES cycles after RESP entry. A late D beat in IDLE is consumed and produces no rsp.

Source files
------------

// File: rtl/tlul_host_bridge.sv
// tlul_host_bridge: single-outstanding command-to-TL-UL A/D bridge.
// Define TLUL_HOST_TIMEOUT_EN to bound the D-channel wait and drain late responses in IDLE.
module tlul_host_bridge #(
   parameter int AW             = 8,
   parameter int SRC_W          = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic             i_cmd_we,
   input  logic [AW-1:0]    i_cmd_addr,
   input  logic [31:0]      i_cmd_wdata,
   input  logic [3:0]       i_cmd_be,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [31:0]      o_rsp_rdata,
   output logic             o_rsp_err,
   output logic             o_a_valid,
   input  logic             i_a_ready,
   output logic [2:0]       o_a_opcode,
   output logic [2:0]       o_a_param,
   output logic [1:0]       o_a_size,
   output logic [SRC_W-1:0] o_a_source,
   output logic [AW-1:0]    o_a_address,
   output logic [3:0]       o_a_mask,
   output logic [31:0]      o_a_data,
   input  logic             i_d_valid,
   output logic             o_d_ready,
   input  logic [2:0]       i_d_opcode,
   input  logic [SRC_W-1:0] i_d_source,
   input  logic [31:0]      i_d_data,
   input  logic             i_d_error
);
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
   state_t state, state_nx;
   logic [SRC_W-1:0] src_cnt;
   logic d_bad, tmo_hit;
   assign o_a_param = 3'd0;
   assign o_a_size  = 2'd2;
   // Get expects AccessAckData, PutFullData expects AccessAck
   assign d_bad = i_d_error | (i_d_source != o_a_source) |
                  (i_d_opcode != ((o_a_opcode == 3'd4) ? 3'd1 : 3'd0));
`ifdef TLUL_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo;
   assign tmo_hit = (tmo == TW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) tmo <= '0;
      else if (state != RESP) tmo <= '0;
      else if (!i_d_valid) tmo <= tmo + 1'b1;
`else
   // RESP waits indefinitely
   assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif
   always_comb begin
      state_nx    = state;
      o_cmd_ready = (state == IDLE);
      o_a_valid   = (state == REQ);
      o_rsp_valid = (state == DONE);
`ifdef TLUL_HOST_TIMEOUT_EN
      o_d_ready   = (state == RESP) || (state == IDLE);
`else
      o_d_ready   = (state == RESP);
`endif
      unique case (state)
         IDLE:    state_nx = i_cmd_valid ? REQ : IDLE;
         REQ:     state_nx = i_a_ready ? RESP : REQ;
         RESP:    state_nx = (i_d_valid || tmo_hit) ? DONE : RESP;
         DONE:    state_nx = i_rsp_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= IDLE;
         src_cnt     <= '0;
         o_a_opcode  <= 3'd0;
         o_a_source  <= '0;
         o_a_address <= '0;
         o_a_mask    <= 4'd0;
         o_a_data    <= 32'd0;
         o_rsp_rdata <= 32'd0;
         o_rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && i_cmd_valid) begin
            o_a_opcode  <= i_cmd_we ? 3'd0 : 3'd4;
            o_a_source  <= src_cnt;
            o_a_address <= i_cmd_addr;
            o_a_mask    <= i_cmd_we ? i_cmd_be : 4'hF;
            o_a_data    <= i_cmd_wdata;
         end
         if (state == REQ && i_a_ready) src_cnt <= src_cnt + 1'b1;
         if (state == RESP && i_d_valid) begin
            o_rsp_rdata <= (i_d_opcode == 3'd1) ? i_d_data : 32'd0;
            o_rsp_err   <= d_bad;
         end else if (state == RESP && tmo_hit) begin
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b1;
         end
      end
   end
endmodule
